// File: rtl/spi_tx_sequencer_if.sv
// Host and shift-register signal bundle for spi_tx_sequencer.
// SPI_TX_READBACK_EN adds the miso / rd_data pair.
interface spi_tx_sequencer_if #(
  parameter int unsigned WORD_W = 64
);
  logic              start;
  logic              abort;
  logic [6:0]        len;
  logic [WORD_W-1:0] d_in;
  logic [WORD_W-1:0] sr_data;
  logic              sr_load;
  logic              sr_en;
  logic              sclk;
  logic              cs_n;
  logic              busy;
  logic              done;
`ifdef SPI_TX_READBACK_EN
  logic              miso;
  logic [WORD_W-1:0] rd_data;

  modport master (
    output start, abort, len, d_in, miso,
    input  sr_data, sr_load, sr_en, sclk, cs_n, busy, done, rd_data
  );
  modport slave (
    input  start, abort, len, d_in, miso,
    output sr_data, sr_load, sr_en, sclk, cs_n, busy, done, rd_data
  );
`else
  modport master (
    output start, abort, len, d_in,
    input  sr_data, sr_load, sr_en, sclk, cs_n, busy, done
  );
  modport slave (
    input  start, abort, len, d_in,
    output sr_data, sr_load, sr_en, sclk, cs_n, busy, done
  );
`endif
endinterface

// File: rtl/spi_tx_sequencer.sv
// SPI mode-0 transmit sequencer: drives load/shift strobes of an external MSB-first
// shift register plus sclk and cs_n. Define SPI_TX_READBACK_EN for MISO capture.
module spi_tx_sequencer #(
  parameter int unsigned WORD_W   = 64,
  parameter int unsigned DIV      = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input logic               CLK,
  input logic               rst_n,
  spi_tx_sequencer_if.slave bus
);
  localparam logic [6:0] MAX_BITS = 7'(WORD_W);
  localparam logic [7:0] DIV_M1   = 8'(DIV - 1);
  localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_LO, SCK_HI, HOLD, FIN} state_t;

  state_t     state;
  logic [7:0] phase_cnt;
  logic [6:0] bit_cnt;
  logic       sr_load_q;
  logic       sr_en_q;
  logic       sclk_q;
  logic       cs_n_q;
  logic       busy_q;
  logic       done_q;

  logic       phase_end;
  logic       take;
  logic [6:0] n_bits;

  assign phase_end = (phase_cnt == '0);
  // FIN doubles as an accept slot, but abort still wins there
  assign take      = bus.start && (bus.len != '0) &&
                     ((state == IDLE) || ((state == FIN) && !bus.abort));
  assign n_bits    = (bus.len > MAX_BITS) ? MAX_BITS : bus.len;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      sr_load_q <= 1'b0;
      sr_en_q   <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sr_load_q <= 1'b0;
      sr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      if (bus.abort && (state != IDLE)) begin
        state     <= IDLE;
        phase_cnt <= '0;
        bit_cnt   <= '0;
        sclk_q    <= 1'b0;
        cs_n_q    <= 1'b1;
        busy_q    <= 1'b0;
      end else begin
        case (state)
          IDLE, FIN: begin
            state <= IDLE;
            if (take) begin
              state     <= SETUP;
              phase_cnt <= SETUP_M1;
              bit_cnt   <= n_bits;
              sr_load_q <= 1'b1;
              cs_n_q    <= 1'b0;
              busy_q    <= 1'b1;
            end
          end
          SETUP: begin
            if (phase_end) begin
              state     <= SCK_LO;
              phase_cnt <= DIV_M1;
            end else begin
              phase_cnt <= phase_cnt - 8'd1;
            end
          end
          SCK_LO: begin
            if (phase_end) begin
              state     <= SCK_HI;
              phase_cnt <= DIV_M1;
              sclk_q    <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt - 8'd1;
            end
          end
          SCK_HI: begin
            if (phase_end) begin
              bit_cnt <= bit_cnt - 7'd1;
              sclk_q  <= 1'b0;
              // the shift for the next bit lands in the low phase, never after the last bit
              if (bit_cnt != 7'd1) begin
                state     <= SCK_LO;
                phase_cnt <= DIV_M1;
                sr_en_q   <= 1'b1;
              end else begin
                state     <= HOLD;
                phase_cnt <= HOLD_M1;
              end
            end else begin
              phase_cnt <= phase_cnt - 8'd1;
            end
          end
          HOLD: begin
            if (phase_end) begin
              state     <= FIN;
              phase_cnt <= '0;
              cs_n_q    <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt - 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sr_data = bus.d_in;
  assign bus.sr_load = sr_load_q;
  assign bus.sr_en   = sr_en_q;
  assign bus.sclk    = sclk_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

`ifdef SPI_TX_READBACK_EN
  logic [WORD_W-1:0] rx_sr;
  logic [WORD_W-1:0] rd_q;

  // rx_sr is cleared on accept so short words come out right-aligned
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr <= '0;
      rd_q  <= '0;
    end else if (!bus.abort || (state == IDLE)) begin
      if (take) begin
        rx_sr <= '0;
      end else if ((state == SCK_HI) && phase_end) begin
        rx_sr <= {rx_sr[WORD_W-2:0], bus.miso};
      end
      if ((state == HOLD) && phase_end) begin
        rd_q <= rx_sr;
      end
    end
  end

  assign bus.rd_data = rd_q;
`endif
endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Self-checking bench for spi_tx_sequencer: vector table, corner sequences and
// randomized transfers against a transfer-level model. Honours SPI_TX_READBACK_EN.
module tb_spi_tx_sequencer;
  localparam int W        = 64;
  localparam int DIV      = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_tx_sequencer_if #(.WORD_W(W)) bus ();

  spi_tx_sequencer #(
    .WORD_W  (W),
    .DIV     (DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .CLK  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // The external shift register that the sequencer controls
  logic [W-1:0] ext_sr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ext_sr <= '0;
    else if (bus.sr_load) ext_sr <= bus.sr_data;
    else if (bus.sr_en)   ext_sr <= {ext_sr[W-2:0], 1'b0};
  end

`ifdef SPI_TX_READBACK_EN
  assign bus.miso = ext_sr[W-1];
`endif

  // Transfer monitor, sampled on the falling edge
  int           busy_n, done_n, load_n, en_n, rise_n, cs_low_n;
  logic [W-1:0] cap;
  logic         prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (bus.busy)    busy_n++;
    if (bus.done)    done_n++;
    if (bus.sr_load) load_n++;
    if (bus.sr_en)   en_n++;
    if (!bus.cs_n)   cs_low_n++;
    if (bus.sclk && !prev_sclk) begin
      rise_n++;
      cap = {cap[W-2:0], ext_sr[W-1]};
    end
    prev_sclk = bus.sclk;
  end

  task automatic clear_mon();
    busy_n = 0; done_n = 0; load_n = 0; en_n = 0; rise_n = 0; cs_low_n = 0;
    cap = '0;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transfer-level reference model
  function automatic int clamp_n(input logic [6:0] l);
    return (int'(l) > W) ? W : int'(l);
  endfunction

  function automatic int busy_cycles(input int n);
    return (n == 0) ? 0 : CS_SETUP + 2 * DIV * n + CS_HOLD;
  endfunction

  function automatic logic [W-1:0] sent_bits(input logic [W-1:0] d, input int n);
    if (n == 0) return '0;
    return d >> (W - n);
  endfunction

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_n == 0; i++) @(negedge clk);
  endtask

  task automatic run_xfer(input logic [6:0] l, input logic [W-1:0] d);
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.len = l; bus.d_in = d;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(600);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_xfer(input string tag, input int e_busy, input int e_rise, input int e_en,
                            input int e_done, input logic [W-1:0] e_cap);
    check_int({tag, " busy"}, busy_n, e_busy);
    check_int({tag, " cs_low"}, cs_low_n, e_busy);
    check_int({tag, " sclk_rises"}, rise_n, e_rise);
    check_int({tag, " sr_en"}, en_n, e_en);
    check_int({tag, " sr_load"}, load_n, e_done);
    check_int({tag, " done"}, done_n, e_done);
    check_word({tag, " serial"}, cap, e_cap);
`ifdef SPI_TX_READBACK_EN
    if (e_done != 0) check_word({tag, " rd_data"}, bus.rd_data, e_cap);
`endif
  endtask

  typedef struct {
    logic [6:0]   len;
    logic [W-1:0] d;
    int           busy;
    int           rise;
    int           en;
    int           done;
    logic [W-1:0] cap;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]   l;
    logic [W-1:0] d;
    logic [W-1:0] rd_keep;
    int           n;

    vecs[0] = '{7'd64,  64'hA5A5_0000_FFFF_1234, 516, 64, 63, 1, 64'hA5A5_0000_FFFF_1234};
    vecs[1] = '{7'd8,   64'hC300_0000_0000_0000,  68,  8,  7, 1, 64'h0000_0000_0000_00C3};
    vecs[2] = '{7'd0,   64'hFFFF_FFFF_FFFF_FFFF,   0,  0,  0, 0, 64'h0};
    vecs[3] = '{7'd100, 64'hA5A5_0000_FFFF_1234, 516, 64, 63, 1, 64'hA5A5_0000_FFFF_1234};
    vecs[4] = '{7'd1,   64'h8000_0000_0000_0000,  12,  1,  0, 1, 64'h1};
    vecs[5] = '{7'd1,   64'h7FFF_FFFF_FFFF_FFFF,  12,  1,  0, 1, 64'h0};
    vecs[6] = '{7'd65,  64'h0123_4567_89AB_CDEF, 516, 64, 63, 1, 64'h0123_4567_89AB_CDEF};
    vecs[7] = '{7'd63,  64'hFFFF_FFFF_FFFF_FFFE, 508, 63, 62, 1, 64'h7FFF_FFFF_FFFF_FFFF};
    vecs[8] = '{7'd16,  64'hBEEF_0000_0000_0000, 132, 16, 15, 1, 64'h0000_0000_0000_BEEF};

    bus.start = 1'b0; bus.abort = 1'b0; bus.len = '0; bus.d_in = '0;
    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    check_int("reset sclk", int'(bus.sclk), 0);
    check_int("reset cs_n", int'(bus.cs_n), 1);
    check_int("reset busy", int'(bus.busy), 0);
    check_int("reset done", int'(bus.done), 0);
    check_int("reset sr_load", int'(bus.sr_load), 0);
    check_int("reset sr_en", int'(bus.sr_en), 0);
`ifdef SPI_TX_READBACK_EN
    check_word("reset rd_data", bus.rd_data, '0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i].len, vecs[i].d);
      check_xfer($sformatf("vec%0d", i), vecs[i].busy, vecs[i].rise, vecs[i].en,
                 vecs[i].done, vecs[i].cap);
    end

    // Abort during the 10th sclk high phase
`ifdef SPI_TX_READBACK_EN
    rd_keep = bus.rd_data;
`else
    rd_keep = '0;
`endif
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.len = 7'd64; bus.d_in = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 1000 && rise_n < 10; i++) @(negedge clk);
    check_int("abort reached rise", rise_n, 10);
    check_int("abort in high phase", int'(bus.sclk), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_int("abort cs_n", int'(bus.cs_n), 1);
    check_int("abort busy", int'(bus.busy), 0);
    check_int("abort sclk", int'(bus.sclk), 0);
    repeat (100) @(negedge clk);
    check_int("abort no more sclk", rise_n, 10);
    check_int("abort no done", done_n, 0);
    check_int("abort sr_en", en_n, 9);
`ifdef SPI_TX_READBACK_EN
    check_word("abort rd_data kept", bus.rd_data, rd_keep);
`endif

    // Asynchronous reset mid SCK_HI, then a full transfer
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.len = 7'd64; bus.d_in = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 1000 && rise_n < 5; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_int("async rst sclk", int'(bus.sclk), 0);
    check_int("async rst cs_n", int'(bus.cs_n), 1);
    check_int("async rst busy", int'(bus.busy), 0);
`ifdef SPI_TX_READBACK_EN
    check_word("async rst rd_data", bus.rd_data, '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(vecs[0].len, vecs[0].d);
    check_xfer("post_reset", vecs[0].busy, vecs[0].rise, vecs[0].en, vecs[0].done, vecs[0].cap);

    // start while busy is dropped
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.len = 7'd8; bus.d_in = 64'hC300_0000_0000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.len = 7'd64; bus.d_in = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(600);
    repeat (40) @(negedge clk);
    check_xfer("busy_start", 68, 8, 7, 1, 64'hC3);

    // Restart accepted in the FIN cycle
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.len = 7'd1; bus.d_in = 64'h8000_0000_0000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && !bus.done; i++) @(negedge clk);
    check_int("fin seen", int'(bus.done), 1);
    bus.start = 1'b1; bus.len = 7'd2; bus.d_in = 64'h4000_0000_0000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    check_int("fin restart load", int'(bus.sr_load), 1);
    for (int i = 0; i < 200 && done_n < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_int("fin restart done", done_n, 2);
    check_int("fin restart busy", busy_n, 32);
    check_int("fin restart rises", rise_n, 3);
    check_word("fin restart serial", cap, 64'h5);

    // abort in IDLE does not block a start
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.len = 7'd3; bus.d_in = 64'hE000_0000_0000_0000;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check_int("idle abort load", int'(bus.sr_load), 1);
    wait_done(600);
    repeat (3) @(negedge clk);
    check_xfer("idle_abort", 28, 3, 2, 1, 64'h7);

    // Randomized transfers against the model
    for (int k = 0; k < 16; k++) begin
      l = 7'($urandom_range(0, 127));
      d = {$urandom, $urandom};
      n = clamp_n(l);
      run_xfer(l, d);
      check_xfer($sformatf("rand%0d", k), busy_cycles(n), n, (n == 0) ? 0 : n - 1,
                 (n == 0) ? 0 : 1, sent_bits(d, n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
